// File: rtl/alu_ex_pipe_if.sv
// ============================================================================
// Module      : alu_ex_pipe_if
// Description : Issue-side and writeback-side signal bundle for alu_ex_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_ex_pipe_if #(
    parameter int DATA_W    = 32,
    parameter int RRF_TAG_W = 6,
    parameter int ROB_TAG_W = 6
);
    logic                 issue_valid_i;
    logic                 issue_ready_o;
    logic [3:0]           alu_op_i;
    logic [DATA_W-1:0]    src1_i;
    logic [DATA_W-1:0]    src2_i;
    logic                 if_write_rrf_i;
    logic [RRF_TAG_W-1:0] rrf_tag_i;
    logic [ROB_TAG_W-1:0] rob_tag_i;
    logic                 kill_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DATA_W-1:0]    result_o;
    logic [RRF_TAG_W-1:0] rrf_tag_o;
    logic [ROB_TAG_W-1:0] rob_tag_o;
    logic                 reorder_buffer_we_o;
    logic                 rename_register_we_o;

    modport slave (
        input  issue_valid_i, alu_op_i, src1_i, src2_i, if_write_rrf_i,
               rrf_tag_i, rob_tag_i, kill_i, ready_i,
        output issue_ready_o, valid_o, result_o, rrf_tag_o, rob_tag_o,
               reorder_buffer_we_o, rename_register_we_o
    );

    modport master (
        output issue_valid_i, alu_op_i, src1_i, src2_i, if_write_rrf_i,
               rrf_tag_i, rob_tag_i, kill_i, ready_i,
        input  issue_ready_o, valid_o, result_o, rrf_tag_o, rob_tag_o,
               reorder_buffer_we_o, rename_register_we_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_ex_pipe.sv
// ============================================================================
// Module      : alu_ex_pipe
// Description : Integer ALU execute pipe, STAGES deep (1..4), elastic with
//               bubble collapse and flush. Optional stall counter enabled by
//               macro ALU_EX_PIPE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ex_pipe #(
    parameter int DATA_W    = 32,
    parameter int RRF_TAG_W = 6,
    parameter int ROB_TAG_W = 6,
    parameter int STAGES    = 2
) (
    input  wire logic      clk_i,
    input  wire logic      reset_n_i,
    alu_ex_pipe_if.slave   bus
`ifdef ALU_EX_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]    stall_cnt_o
`endif
);
    localparam int         c_SHAMT_W = $clog2(DATA_W);
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;

    logic [c_SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]    w_alu;
    logic                 w_accept;
    logic [STAGES-1:0]    w_load;
    logic [STAGES-1:0]    w_vld;
    logic [STAGES-1:0]    w_wr;
    logic [DATA_W-1:0]    w_res [STAGES];
    logic [RRF_TAG_W-1:0] w_rrf [STAGES];
    logic [ROB_TAG_W-1:0] w_rob [STAGES];

    assign w_shamt = bus.src2_i[c_SHAMT_W-1:0];

    always_comb begin : p_alu
        w_alu = '0;
        case (bus.alu_op_i)
            c_OP_ADD:  w_alu = bus.src1_i + bus.src2_i;
            c_OP_SUB:  w_alu = bus.src1_i - bus.src2_i;
            c_OP_AND:  w_alu = bus.src1_i & bus.src2_i;
            c_OP_OR:   w_alu = bus.src1_i | bus.src2_i;
            c_OP_XOR:  w_alu = bus.src1_i ^ bus.src2_i;
            c_OP_SLL:  w_alu = bus.src1_i << w_shamt;
            c_OP_SRL:  w_alu = bus.src1_i >> w_shamt;
            c_OP_SRA:  w_alu = $signed(bus.src1_i) >>> w_shamt;
            c_OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            c_OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (bus.src1_i < bus.src2_i)};
            default:   w_alu = '0;
        endcase
    end

    // A stage may load when it, or any stage downstream of it, has a hole,
    // or when the output is being consumed: this is what collapses bubbles.
    always_comb begin : p_load
        logic w_free;
        w_load = '0;
        w_free = bus.ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_free    = w_free | ~w_vld[k];
            w_load[k] = w_free;
        end
    end

    assign bus.issue_ready_o = w_load[0] & ~bus.kill_i;
    assign w_accept          = bus.issue_valid_i & bus.issue_ready_o;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic                 w_in_vld;
        logic                 w_in_wr;
        logic [DATA_W-1:0]    w_in_res;
        logic [RRF_TAG_W-1:0] w_in_rrf;
        logic [ROB_TAG_W-1:0] w_in_rob;
        logic                 r_vld;
        logic                 r_wr;
        logic [DATA_W-1:0]    r_res;
        logic [RRF_TAG_W-1:0] r_rrf;
        logic [ROB_TAG_W-1:0] r_rob;

        if (g == 0) begin : g_head
            assign w_in_vld = w_accept;
            assign w_in_wr  = bus.if_write_rrf_i;
            assign w_in_res = w_alu;
            assign w_in_rrf = bus.rrf_tag_i;
            assign w_in_rob = bus.rob_tag_i;
        end else begin : g_tail
            assign w_in_vld = w_vld[g-1];
            assign w_in_wr  = w_wr[g-1];
            assign w_in_res = w_res[g-1];
            assign w_in_rrf = w_rrf[g-1];
            assign w_in_rob = w_rob[g-1];
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_vld <= 1'b0;
                r_wr  <= 1'b0;
                r_res <= '0;
                r_rrf <= '0;
                r_rob <= '0;
            end else if (bus.kill_i) begin
                r_vld <= 1'b0;
            end else if (w_load[g]) begin
                r_vld <= w_in_vld;
                if (w_in_vld) begin
                    r_wr  <= w_in_wr;
                    r_res <= w_in_res;
                    r_rrf <= w_in_rrf;
                    r_rob <= w_in_rob;
                end
            end
        end

        assign w_vld[g] = r_vld;
        assign w_wr[g]  = r_wr;
        assign w_res[g] = r_res;
        assign w_rrf[g] = r_rrf;
        assign w_rob[g] = r_rob;
    end

    assign bus.valid_o              = w_vld[STAGES-1];
    assign bus.result_o             = w_res[STAGES-1];
    assign bus.rrf_tag_o            = w_rrf[STAGES-1];
    assign bus.rob_tag_o            = w_rob[STAGES-1];
    assign bus.reorder_buffer_we_o  = w_vld[STAGES-1] & bus.ready_i;
    assign bus.rename_register_we_o = w_vld[STAGES-1] & bus.ready_i & w_wr[STAGES-1];

`ifdef ALU_EX_PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_vld[STAGES-1] && !bus.ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_ex_pipe.sv
// ============================================================================
// Module      : tb_alu_ex_pipe
// Description : Self-checking bench for alu_ex_pipe: directed cases plus
//               randomized traffic against an op-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ex_pipe;
    parameter int S = 2;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  rrf;
        logic [5:0]  rob;
        logic        wr;
        int          pos;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] stall_cnt;
    int          n_checks;
    int          n_fail;
    op_t         q[$];
    op_t         m_new;
    logic        m_vld;
    logic        m_acc;
    logic [31:0] m_stall;

    alu_ex_pipe_if #(.DATA_W(32), .RRF_TAG_W(6), .ROB_TAG_W(6)) bus ();

    alu_ex_pipe #(.DATA_W(32), .RRF_TAG_W(6), .ROB_TAG_W(6), .STAGES(S)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .bus        (bus)
`ifdef ALU_EX_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

`ifndef ALU_EX_PIPE_STALL_CNT_EN
    assign stall_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        r  = 32'h0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Reference: an in-order list of ops, each with the stage it occupies.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_stall = 32'h0;
        end else begin
            m_vld = (q.size() > 0) && (q[0].pos == S);
            m_acc = bus.issue_valid_i && !bus.kill_i && ((q.size() < S) || bus.ready_i);
            if (m_vld && !bus.ready_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (bus.kill_i) begin
                q.delete();
            end else begin
                if (m_vld && bus.ready_i) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) begin
                    int lim;
                    lim = (i == 0) ? S : q[i-1].pos - 1;
                    q[i].pos = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
                end
                if (m_acc) begin
                    m_new.res = ref_alu(bus.alu_op_i, bus.src1_i, bus.src2_i);
                    m_new.rrf = bus.rrf_tag_i;
                    m_new.rob = bus.rob_tag_i;
                    m_new.wr  = bus.if_write_rrf_i;
                    m_new.pos = 1;
                    q.push_back(m_new);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_vld;
        #1;
        if (rst_n) begin
            e_vld = (q.size() > 0) && (q[0].pos == S);
            check("issue_ready_o", bus.issue_ready_o, !bus.kill_i && ((q.size() < S) || bus.ready_i));
            check("valid_o", bus.valid_o, e_vld);
            check("rob_we", bus.reorder_buffer_we_o, e_vld && bus.ready_i);
            check("rrf_we", bus.rename_register_we_o, e_vld && bus.ready_i && q[0].wr);
            if (e_vld) begin
                check("result_o", bus.result_o, q[0].res);
                check("rrf_tag_o", bus.rrf_tag_o, q[0].rrf);
                check("rob_tag_o", bus.rob_tag_o, q[0].rob);
            end
`ifdef ALU_EX_PIPE_STALL_CNT_EN
            check("stall_cnt_o", stall_cnt, m_stall);
`endif
        end
    end

    task automatic drv(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, input logic kl, input logic [5:0] rob);
        bus.issue_valid_i  = v;
        bus.alu_op_i       = op;
        bus.src1_i         = a;
        bus.src2_i         = b;
        bus.if_write_rrf_i = 1'b1;
        bus.rrf_tag_i      = 6'h15;
        bus.rob_tag_i      = rob;
        bus.ready_i        = rdy;
        bus.kill_i         = kl;
    endtask

    task automatic drv_rand(input int kill_odds);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: b = 32'hFFFF_FFFF;
            default: ;
        endcase
        drv($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b,
            $urandom_range(0, 3) != 0, $urandom_range(0, kill_odds) == 0, 6'($urandom));
        bus.if_write_rrf_i = 1'($urandom);
        bus.rrf_tag_i      = 6'($urandom);
    endtask

    initial begin
        int          lat;
        int          k;
        int          stalls;
        int          idx [3];
        logic [31:0] got [3];
        logic [31:0] base;
        n_checks = 0;
        n_fail   = 0;
        base     = 0;
        rst_n    = 1'b0;
        drv(0, 0, 0, 0, 1, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_result_o", bus.result_o, 0);
        check("rst_tags", {bus.rrf_tag_o, bus.rob_tag_o}, 0);
        check("rst_we", {bus.reorder_buffer_we_o, bus.rename_register_we_o}, 0);
        check("ref_model_pin", ref_alu(4'd7, 32'hF000_0000, 32'd36), 32'hFF00_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 5+7: latency equals the pipe depth, tags carried through
        drv(1, 4'd0, 32'd5, 32'd7, 1, 0, 6'h2A);
        lat = 0;
        do begin
            @(negedge clk);
            drv(0, 0, 0, 0, 1, 0, 0);
            #2;
            lat++;
        end while (!bus.valid_o && lat < 10);
        check("add_latency", lat, S);
        check("add_result", bus.result_o, 32'd12);
        check("add_tags", {bus.rrf_tag_o, bus.rob_tag_o}, {6'h15, 6'h2A});
        check("add_we", {bus.reorder_buffer_we_o, bus.rename_register_we_o}, 2'b11);

        // Back-to-back SUB / SRA / SLTU
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            case (c)
                0: drv(1, 4'd1, 32'd3, 32'd5, 1, 0, 6'd1);
                1: drv(1, 4'd7, 32'h8000_0000, 32'd4, 1, 0, 6'd2);
                2: drv(1, 4'd9, 32'd1, 32'hFFFF_FFFF, 1, 0, 6'd3);
                default: drv(0, 0, 0, 0, 1, 0, 0);
            endcase
            #2;
            if (bus.valid_o && k < 3) begin
                got[k] = bus.result_o;
                idx[k] = c;
                k++;
            end
        end
        check("b2b_count", k, 3);
        check("b2b_sub", got[0], 32'hFFFF_FFFE);
        check("b2b_sra", got[1], 32'hF800_0000);
        check("b2b_sltu", got[2], 32'd1);
        check("b2b_consecutive", idx[2] - idx[0], 2);

        // Writeback stalls for 3 cycles while issue keeps pushing
        stalls = 0;
        for (int i = 0; i < 40 && stalls < 3; i++) begin
            @(negedge clk);
            drv(1, 4'd0, 32'(i), 32'd100, 0, 0, 6'(i));
            #2;
            if (bus.valid_o) begin
                if (stalls == 0) base = stall_cnt;
                stalls++;
            end
        end
        check("stall_cycles", stalls, 3);
        check("stall_issue_ready", bus.issue_ready_o, 0);
        @(negedge clk);
        drv(0, 0, 0, 0, 1, 0, 0);
        #2;
`ifdef ALU_EX_PIPE_STALL_CNT_EN
        check("stall_cnt_delta", stall_cnt - base, 32'd3);
`endif
        repeat (S + 4) @(negedge clk);

        // Kill with ops in flight and a simultaneous issue
        @(negedge clk); drv(1, 4'd0, 32'd10, 32'd1, 1, 0, 6'd7);
        @(negedge clk); drv(1, 4'd0, 32'd20, 32'd2, 1, 0, 6'd8);
        @(negedge clk); drv(1, 4'd0, 32'd30, 32'd3, 1, 1, 6'd9);
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            drv(0, 0, 0, 0, 1, 0, 0);
            #2;
            check("kill_no_valid", bus.valid_o, 0);
        end
        @(negedge clk);
        drv(1, 4'd0, 32'd1, 32'd2, 1, 0, 6'd11);
        lat = 0;
        do begin
            @(negedge clk);
            drv(0, 0, 0, 0, 1, 0, 0);
            #2;
            lat++;
        end while (!bus.valid_o && lat < 10);
        check("post_kill_latency", lat, S);
        check("post_kill_result", bus.result_o, 32'd3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drv_rand(40);
        end

        // Asynchronous reset pulse between edges
        @(negedge clk);
        drv(1, 4'd0, 32'd1, 32'd1, 0, 0, 6'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.valid_o, 0);
        check("async_rst_result", bus.result_o, 0);
        check("async_rst_we", bus.reorder_buffer_we_o, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drv_rand(60);
        end

        @(negedge clk);
        drv(0, 0, 0, 0, 1, 0, 0);
        repeat (S + 4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
